victim_way_selector: RTL and testbench
======================================

Name: victim_way_selector

Overview:
- Cache-replacement stage directly downstream of the 5-bit Fibonacci LFSR; consumes its output as the random source.
- On each miss request, picks the victim way of the addressed set: an invalid way if one exists, otherwise a random unlocked way.
- Requests `rand_en` advances from the LFSR, one per draw.
- Delivers the chosen way to the cache controller over a valid/ack handshake.

Parameters:
- WAYS, 4, associativity; must be a power of two, 2..32.
- WAY_BITS, 2, log2(WAYS); width of way index.
- RAND_BITS, 5, width of LFSR input; must be >= WAY_BITS.
- MAX_RETRY, 3, random draws landing on locked ways before fallback; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  miss request; accepted only when busy=0.
- set_valid  input  WAYS  valid bits of the addressed set; sampled on accept.
- set_lock  input  WAYS  lock bits (way not replaceable); sampled on accept.
- rand_in  input  RAND_BITS  current LFSR value.
- rand_en  output  1  one-cycle pulse: LFSR must advance.
- busy  output  1  high in every state except IDLE.
- victim_valid  output  1  victim_way/all_locked/from_invalid are valid.
- victim_way  output  WAY_BITS  selected way.
- from_invalid  output  1  victim was chosen because it was invalid.
- all_locked  output  1  no replaceable way; victim_way=0 is meaningless.
- victim_ack  input  1  consumer accepts the response.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, retry counter=0, captured valid/lock=0. All outputs are 0.
- FSM states: IDLE, PICK, DRAW, RESP.
- IDLE:
  - busy=0.
  - On req=1: capture set_valid and set_lock into registers; go to PICK.
  - req while busy=1 is ignored, not queued.
- PICK (one cycle):
  - cand = ~valid & ~lock.
  - If cand != 0: victim = lowest set index, from_invalid=1; go to RESP.
  - Else if lock all ones: all_locked=1, victim_way=0; go to RESP.
  - Else: retry=0; go to DRAW.
- DRAW (one cycle per draw):
  - idx = rand_in[WAY_BITS-1:0]; rand_en=1 this cycle.
  - If lock[idx]=0: victim=idx, from_invalid=0; go to RESP.
  - Else if retry==MAX_RETRY-1: victim = lowest unlocked index, from_invalid=0; go to RESP.
  - Else: retry++; stay in DRAW.
  - Counter width covers MAX_RETRY; no wrap occurs.
- rand_en is asserted only in DRAW, never in IDLE, PICK, or RESP.
- RESP:
  - victim_valid=1. victim_way, from_invalid, and all_locked are registered and held stable until ack.
  - On victim_ack=1: next cycle state=IDLE, victim_valid=0, and the response outputs clear to 0.
- victim_ack outside RESP is ignored.
- Latency, request accepted at edge 0:
  - Invalid-way or all-locked path: victim_valid high after edge 2.
  - Random path with first draw unlocked: high after edge 3.
  - Worst case: high after edge 2+MAX_RETRY.
- Back-to-back: ack in cycle N returns to IDLE after edge N+1; a new req is accepted at the earliest from the edge N+2.
- Input changes to set_valid/set_lock after accept have no effect on the current operation.

Test Plan:
- Reset then idle: rst_n low mid-DRAW -> state IDLE, busy=0, rand_en=0, victim_valid=0 immediately (asynchronous), with no clock edge.
- Invalid preference: set_valid=4'b1011, lock=0, req -> victim_way=2, from_invalid=1, victim_valid 2 cycles after accept, rand_en never pulses.
- Random pick: valid=4'hF, lock=0, rand_in=5'b10110 -> one rand_en pulse; victim_way=2, from_invalid=0, victim_valid at accept+3.
- Locked retries then fallback: valid=4'hF, lock=4'b1101, rand_in held 5'b00000 (way 0 locked) -> exactly 3 rand_en pulses, then victim_way=1 from fallback.
- All locked: valid=4'hF, lock=4'hF -> all_locked=1, victim_way=0, no rand_en pulse; victim_valid held across 5 cycles of ack=0, clears one cycle after ack=1.
- Busy/ignore: second req pulsed while in DRAW -> ignored; after ack, new req with valid=4'b0111 -> victim_way=3.

Source files
------------

// File: rtl/victim_way_selector.sv
// Victim-way selection for a set-associative cache: prefers an invalid unlocked way,
// otherwise draws random unlocked ways from an external LFSR with a bounded retry fallback.
module victim_way_selector #(
    parameter int WAYS      = 4,
    parameter int WAY_BITS  = 2,
    parameter int RAND_BITS = 5,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic [WAYS-1:0]      set_valid,
    input  logic [WAYS-1:0]      set_lock,
    input  logic [RAND_BITS-1:0] rand_in,
    output logic                 rand_en,
    output logic                 busy,
    output logic                 victim_valid,
    output logic [WAY_BITS-1:0]  victim_way,
    output logic                 from_invalid,
    output logic                 all_locked,
    input  logic                 victim_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        DRAW = 2'd2,
        RESP = 2'd3
    } state_t;

    // The retry counter only ever holds 0..MAX_RETRY-1.
    localparam int CNT_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    state_t              state, next_state;
    logic [CNT_W-1:0]    retry;
    logic [WAYS-1:0]     valid_q, lock_q;
    logic [WAY_BITS-1:0] way_q;
    logic                from_inv_q, all_locked_q;

    logic [WAYS-1:0]     cand;
    logic [WAY_BITS-1:0] draw_idx;
    logic                draw_hit, retry_last, have_cand, lock_full;

    function automatic logic [WAY_BITS-1:0] lowest_set(input logic [WAYS-1:0] v);
        lowest_set = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = WAY_BITS'(i);
        end
    endfunction

    // Only the low bits of the LFSR word select a way.
    generate
        if (RAND_BITS > WAY_BITS) begin : g_rand_hi
            logic unused_rand_hi;
            assign unused_rand_hi = ^rand_in[RAND_BITS-1:WAY_BITS];
        end
    endgenerate

    assign cand       = ~valid_q & ~lock_q;
    assign have_cand  = |cand;
    assign lock_full  = &lock_q;
    assign draw_idx   = rand_in[WAY_BITS-1:0];
    assign draw_hit   = ~lock_q[draw_idx];
    assign retry_last = (retry == CNT_W'(MAX_RETRY - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets a default before the case, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req) next_state = PICK;
            PICK: begin
                if (have_cand || lock_full) next_state = RESP;
                else                        next_state = DRAW;
            end
            DRAW: if (draw_hit || retry_last) next_state = RESP;
            RESP: if (victim_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all datapath registers are reset too, so the outputs read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry        <= '0;
            valid_q      <= '0;
            lock_q       <= '0;
            way_q        <= '0;
            from_inv_q   <= 1'b0;
            all_locked_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        valid_q <= set_valid;
                        lock_q  <= set_lock;
                    end
                end
                PICK: begin
                    if (have_cand) begin
                        way_q      <= lowest_set(cand);
                        from_inv_q <= 1'b1;
                    end else if (lock_full) begin
                        way_q        <= '0;
                        all_locked_q <= 1'b1;
                    end else begin
                        retry <= '0;
                    end
                end
                DRAW: begin
                    if (draw_hit) begin
                        way_q      <= draw_idx;
                        from_inv_q <= 1'b0;
                    end else if (retry_last) begin
                        // At least one way is unlocked here, otherwise PICK flagged all_locked.
                        way_q      <= lowest_set(~lock_q);
                        from_inv_q <= 1'b0;
                    end else begin
                        retry <= retry + 1'b1;
                    end
                end
                RESP: begin
                    if (victim_ack) begin
                        way_q        <= '0;
                        from_inv_q   <= 1'b0;
                        all_locked_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy         = (state != IDLE);
        rand_en      = (state == DRAW);
        victim_valid = (state == RESP);
        victim_way   = way_q;
        from_invalid = from_inv_q;
        all_locked   = all_locked_q;
    end

endmodule

// File: tb/tb_victim_way_selector.sv
// Directed bench for victim_way_selector: a vector table for single operations plus
// hand-written sequences for hold-until-ack, ignored requests and asynchronous reset.
module tb_victim_way_selector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [3:0] set_valid, set_lock;
    logic [4:0] rand_in;
    logic       rand_en, busy, victim_valid, from_invalid, all_locked, victim_ack;
    logic [1:0] victim_way;

    int n_checks = 0;
    int n_pass   = 0;

    victim_way_selector #(
        .WAYS(4), .WAY_BITS(2), .RAND_BITS(5), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .set_valid(set_valid), .set_lock(set_lock), .rand_in(rand_in),
        .rand_en(rand_en), .busy(busy), .victim_valid(victim_valid),
        .victim_way(victim_way), .from_invalid(from_invalid),
        .all_locked(all_locked), .victim_ack(victim_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] lock;
        logic [4:0] rnd;
        logic [1:0] way;
        logic       inv;
        logic       alk;
        int         lat;
        int         pulses;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else             n_pass++;
    endtask

    // Waits (bounded) for victim_valid, counting edges since the accept edge and rand_en cycles.
    task automatic wait_resp(inout int lat, inout int pulses, output bit seen);
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (victim_valid) seen = 1;
            else begin
                if (rand_en) pulses++;
                @(posedge clk); #1;
                lat++;
            end
        end
    endtask

    // Drives one request in the cycle after an edge; it is accepted at the following edge.
    task automatic run_op(input vec_t v, input string tag);
        int lat, pulses;
        bit seen;
        set_valid = v.valid; set_lock = v.lock; rand_in = v.rnd; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        set_valid = ~v.valid;   // post-accept changes must not matter
        set_lock  = ~v.lock;
        lat = 1; pulses = 0;
        wait_resp(lat, pulses, seen);
        check({tag, " resp_seen"}, int'(seen), 1);
        check({tag, " latency"}, lat, v.lat);
        check({tag, " rand_en_pulses"}, pulses, v.pulses);
        check({tag, " victim_way"}, int'(victim_way), int'(v.way));
        check({tag, " from_invalid"}, int'(from_invalid), int'(v.inv));
        check({tag, " all_locked"}, int'(all_locked), int'(v.alk));
        check({tag, " busy_in_resp"}, int'(busy), 1);
        check({tag, " rand_en_in_resp"}, int'(rand_en), 0);
    endtask

    task automatic ack_and_check(input string tag);
        victim_ack = 1'b1;
        @(posedge clk); #1;
        victim_ack = 1'b0;
        check({tag, " valid_after_ack"}, int'(victim_valid), 0);
        check({tag, " busy_after_ack"}, int'(busy), 0);
        check({tag, " outputs_cleared"}, int'({victim_way, from_invalid, all_locked}), 0);
    endtask

    initial begin
        int  lat, pulses;
        bit  seen;
        vec_t v;

        //          valid     lock      rand      way   inv   alk  lat pulses
        vecs[0] = '{4'b1011, 4'b0000, 5'b00000, 2'd2, 1'b1, 1'b0, 2, 0};
        vecs[1] = '{4'b1111, 4'b0000, 5'b10110, 2'd2, 1'b0, 1'b0, 3, 1};
        vecs[2] = '{4'b1111, 4'b1101, 5'b00000, 2'd1, 1'b0, 1'b0, 5, 3};
        vecs[3] = '{4'b1111, 4'b1111, 5'b00011, 2'd0, 1'b0, 1'b1, 2, 0};
        vecs[4] = '{4'b0111, 4'b0000, 5'b00000, 2'd3, 1'b1, 1'b0, 2, 0};
        vecs[5] = '{4'b0000, 4'b0001, 5'b00000, 2'd1, 1'b1, 1'b0, 2, 0};
        vecs[6] = '{4'b1111, 4'b0111, 5'b11011, 2'd3, 1'b0, 1'b0, 3, 1};
        vecs[7] = '{4'b1010, 4'b0101, 5'b00001, 2'd1, 1'b0, 1'b0, 3, 1};

        rst_n = 1'b0; req = 1'b0; victim_ack = 1'b0;
        set_valid = '0; set_lock = '0; rand_in = '0;
        #1;
        check("reset busy", int'(busy), 0);
        check("reset outputs", int'({rand_en, victim_valid, victim_way, from_invalid, all_locked}), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
            ack_and_check($sformatf("vec%0d", i));
        end

        // All locked: response held across 5 cycles without ack.
        run_op(vecs[3], "hold");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold c%0d valid", c), int'(victim_valid), 1);
            check($sformatf("hold c%0d flags", c), int'({victim_way, all_locked, rand_en}), 3'b001 << 1);
        end
        ack_and_check("hold");

        // Request pulsed during DRAW is ignored and not queued.
        set_valid = 4'hF; set_lock = 4'b1101; rand_in = 5'b00000; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("ignore in_draw", int'(rand_en), 1);
        req = 1'b1; set_valid = 4'b0111; set_lock = 4'b0000;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0; pulses = 0;
        wait_resp(lat, pulses, seen);
        check("ignore resp_seen", int'(seen), 1);
        check("ignore victim_way", int'(victim_way), 1);
        check("ignore from_invalid", int'(from_invalid), 0);
        ack_and_check("ignore");
        @(posedge clk); #1;
        check("ignore not_queued", int'(busy), 0);
        v = vecs[4];
        run_op(v, "after_ignore");
        ack_and_check("after_ignore");

        // Asynchronous reset in the middle of DRAW.
        set_valid = 4'hF; set_lock = 4'b1101; rand_in = 5'b00000; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("areset pre_draw", int'(rand_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check("areset busy", int'(busy), 0);
        check("areset outputs", int'({rand_en, victim_valid, victim_way, from_invalid, all_locked}), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("areset stays_idle", int'({busy, rand_en}), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
